// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS-subset datapath: decodes opcode/funct and drives every mux select and write enable.
// Define CU_OVERFLOW_TRAP_EN to build the overflow/illegal-opcode exception path (EXCEPT, EXCEPT_WAIT, EXCEPT_JMP).
module multicycle_control #(
   parameter int unsigned MEM_WAIT        = 2,
   parameter logic [2:0]  TRAP_VECTOR_SEL = 3'd3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   input  logic       zero_i,
   input  logic       overflow_i,
   output logic [1:0] alu_src_a_o,
   output logic [2:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic [2:0] pc_source_o,
   output logic       pc_write_o,
   output logic [2:0] iord_o,
   output logic       mem_wr_o,
   output logic       ir_write_o,
   output logic       mdr_write_o,
   output logic       write_reg_a_o,
   output logic       write_reg_b_o,
   output logic       aluout_write_o,
   output logic [3:0] mem_to_reg_o,
   output logic [1:0] reg_dst_o,
   output logic       reg_write_o,
   output logic       epc_write_o,
   output logic [4:0] state_out_o
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_WAIT);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;

   typedef enum logic [4:0] {
      S_RESET       = 5'd0,
      S_FETCH       = 5'd1,
      S_FETCH_WAIT  = 5'd2,
      S_IR_LOAD     = 5'd3,
      S_DECODE      = 5'd4,
      S_EXEC_R      = 5'd5,
      S_WB_R        = 5'd6,
      S_EXEC_I      = 5'd7,
      S_WB_I        = 5'd8,
      S_ADDR        = 5'd9,
      S_MEM_RD      = 5'd10,
      S_MEM_WAIT    = 5'd11,
      S_WB_LD       = 5'd12,
      S_MEM_WR      = 5'd13,
      S_BRANCH      = 5'd14,
      S_JUMP        = 5'd15,
      S_JAL         = 5'd16,
      S_ILLEGAL     = 5'd17,
      S_EXCEPT      = 5'd18,
      S_EXCEPT_WAIT = 5'd19,
      S_EXCEPT_JMP  = 5'd20
   } state_t;

   typedef struct packed {
      logic [1:0] alu_src_a;
      logic [2:0] alu_src_b;
      logic [2:0] alu_op;
      logic [2:0] pc_source;
      logic       pc_write;
      logic [2:0] iord;
      logic       mem_wr;
      logic       ir_write;
      logic       mdr_write;
      logic       write_reg_a;
      logic       write_reg_b;
      logic       aluout_write;
      logic [3:0] mem_to_reg;
      logic [1:0] reg_dst;
      logic       reg_write;
      logic       epc_write;
      logic       br;
      logic       br_ne;
   } ctrl_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic             wait_done;
   logic             trap_ovf;

`ifdef CU_OVERFLOW_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
   assign trap_ovf    = overflow_i;
   assign epc_write_o = ctrl_q.epc_write;
`else
   localparam logic TRAP_EN = 1'b0;
   logic unused_trap;
   assign trap_ovf    = 1'b0;
   assign epc_write_o = 1'b0;
   assign unused_trap = ^{overflow_i, TRAP_VECTOR_SEL, ctrl_q.epc_write};
`endif

   function automatic logic is_wait(state_t s);
      return (s == S_FETCH_WAIT) || (s == S_MEM_WAIT) || (s == S_EXCEPT_WAIT);
   endfunction

   // Per-state output decode; branch pc_write is finished combinationally with zero_i.
   function automatic ctrl_t ctrl_of(state_t s, logic [5:0] op, logic [5:0] fn);
      ctrl_t c;
      c = '0;
      case (s)
         S_RESET:   begin c.reg_write = 1'b1; c.reg_dst = 2'd1; c.mem_to_reg = 4'd5; end
         S_FETCH:   begin c.alu_src_b = 3'd1; c.alu_op = 3'd1; c.pc_write = 1'b1; end
         S_IR_LOAD: c.ir_write = 1'b1;
         S_DECODE:  begin
            c.write_reg_a  = 1'b1;
            c.write_reg_b  = 1'b1;
            c.aluout_write = 1'b1;
            c.alu_src_b    = 3'd3;
            c.alu_op       = 3'd1;
         end
         S_EXEC_R:  begin
            c.alu_src_a    = 2'd2;
            c.aluout_write = 1'b1;
            c.alu_op       = (fn == FN_SUB) ? 3'd2 : ((fn == FN_AND) ? 3'd3 : 3'd1);
         end
         S_WB_R:    begin c.reg_write = 1'b1; c.reg_dst = 2'd3; end
         S_EXEC_I, S_ADDR: begin
            c.alu_src_a    = 2'd2;
            c.alu_src_b    = 3'd2;
            c.alu_op       = 3'd1;
            c.aluout_write = 1'b1;
         end
         S_WB_I:    c.reg_write = 1'b1;
         S_MEM_RD:  c.iord = 3'd1;
         S_WB_LD:   begin c.mdr_write = 1'b1; c.reg_write = 1'b1; c.mem_to_reg = 4'd1; end
         S_MEM_WR:  begin c.iord = 3'd1; c.mem_wr = 1'b1; end
         S_BRANCH:  begin
            c.alu_src_a = 2'd2;
            c.alu_op    = 3'd2;
            c.pc_source = 3'd1;
            c.br        = 1'b1;
            c.br_ne     = (op == OP_BNE);
         end
         S_JUMP:    begin c.pc_source = 3'd2; c.pc_write = 1'b1; end
         S_JAL:     begin
            c.reg_write  = 1'b1;
            c.reg_dst    = 2'd2;
            c.mem_to_reg = 4'd2;
            c.pc_source  = 3'd2;
            c.pc_write   = 1'b1;
         end
`ifdef CU_OVERFLOW_TRAP_EN
         S_EXCEPT:  begin c.alu_src_b = 3'd1; c.alu_op = 3'd2; c.epc_write = 1'b1; c.iord = 3'd2; end
         S_EXCEPT_JMP: begin c.pc_source = TRAP_VECTOR_SEL; c.pc_write = 1'b1; end
`endif
         default:   ;
      endcase
      return c;
   endfunction

   assign wait_done = (cnt_q == CNT_W'(1));

   // Next-state and wait-counter logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_RESET:      state_d = S_FETCH;
         S_FETCH:      state_d = S_FETCH_WAIT;
         S_FETCH_WAIT: if (wait_done) state_d = S_IR_LOAD;
         S_IR_LOAD:    state_d = S_DECODE;
         S_DECODE: begin
            case (opcode_i)
               OP_RTYPE:       state_d = ((funct_i == FN_ADD) || (funct_i == FN_SUB) || (funct_i == FN_AND))
                                         ? S_EXEC_R : S_ILLEGAL;
               OP_ADDI:        state_d = S_EXEC_I;
               OP_LW, OP_SW:   state_d = S_ADDR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_J:           state_d = S_JUMP;
               OP_JAL:         state_d = S_JAL;
               default:        state_d = S_ILLEGAL;
            endcase
         end
         S_EXEC_R:     state_d = (trap_ovf && (funct_i != FN_AND)) ? S_EXCEPT : S_WB_R;
         S_EXEC_I:     state_d = trap_ovf ? S_EXCEPT : S_WB_I;
         S_ADDR:       state_d = (opcode_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:     state_d = S_MEM_WAIT;
         S_MEM_WAIT:   if (wait_done) state_d = S_WB_LD;
         S_ILLEGAL:    state_d = TRAP_EN ? S_EXCEPT : S_FETCH;
`ifdef CU_OVERFLOW_TRAP_EN
         S_EXCEPT:      state_d = S_EXCEPT_WAIT;
         S_EXCEPT_WAIT: if (wait_done) state_d = S_EXCEPT_JMP;
`endif
         default:      state_d = S_FETCH;
      endcase
      if (is_wait(state_d) && (state_d != state_q)) begin
         cnt_d = WAIT_INIT;
      end else if (is_wait(state_q)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   assign ctrl_d = ctrl_of(state_d, opcode_i, funct_i);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_RESET;
         cnt_q   <= '0;
         ctrl_q  <= ctrl_of(S_RESET, 6'd0, 6'd0);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign alu_src_a_o    = ctrl_q.alu_src_a;
   assign alu_src_b_o    = ctrl_q.alu_src_b;
   assign alu_op_o       = ctrl_q.alu_op;
   assign pc_source_o    = ctrl_q.pc_source;
   assign pc_write_o     = ctrl_q.pc_write | (ctrl_q.br & (zero_i ^ ctrl_q.br_ne));
   assign iord_o         = ctrl_q.iord;
   assign mem_wr_o       = ctrl_q.mem_wr;
   assign ir_write_o     = ctrl_q.ir_write;
   assign mdr_write_o    = ctrl_q.mdr_write;
   assign write_reg_a_o  = ctrl_q.write_reg_a;
   assign write_reg_b_o  = ctrl_q.write_reg_b;
   assign aluout_write_o = ctrl_q.aluout_write;
   assign mem_to_reg_o   = ctrl_q.mem_to_reg;
   assign reg_dst_o      = ctrl_q.reg_dst;
   assign reg_write_o    = ctrl_q.reg_write;
   assign state_out_o    = state_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multicycle control unit for the MIPS-subset datapath. It replaces the fixed fetch/ADD sequencer with an opcode/funct-decoding Moore FSM. The FSM supports R-type add/sub/and, addi, lw, sw, beq, bne, j and jal, with a configurable memory wait. It drives every datapath mux select and write enable, and takes ALU flags back for branch and overflow decisions.

## Interface
- MEM_WAIT, 2, memory read-latency wait cycles after each read request (1..15)
- TRAP_VECTOR_SEL, 3'd3, pc_source value that selects the exception vector
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero, overflow  in  1 each  ALU flags, valid in the cycle of the ALU operation
- alu_src_a  out  2  0 = PC, 2 = reg A
- alu_src_b  out  3  0 = reg B, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2
- alu_op  out  3  0 = pass A, 1 = add, 2 = sub, 3 = and
- pc_source  out  3  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = exception vector
- pc_write  out  1  unconditional PC load
- iord  out  3  0 = PC, 1 = ALUOut, 2 = exception address
- mem_wr, ir_write, mdr_write  out  1 each  memory write; IR load; MDR load
- write_reg_a, write_reg_b, aluout_write  out  1 each  register loads
- mem_to_reg  out  4  0 = ALUOut, 1 = MDR, 2 = PC, 5 = stack-pointer init constant
- reg_dst  out  2  0 = rt, 1 = $29, 2 = $31, 3 = rd
- reg_write  out  1  register file write
- epc_write  out  1  EPC load (trap build only; tied 0 otherwise)
- state_out  out  5  current state code, for debug

## Operation
- Moore FSM. Every output is decoded from the state alone. Every output not listed for a state is 0.
- Memory-wait counter: 4 bits. It loads MEM_WAIT on entry to FETCH_WAIT or MEM_WAIT_ST and decrements each cycle. The state exits when the counter reaches 1.
- RESET: reg_write=1, reg_dst=1, mem_to_reg=5, which initialises the stack pointer. Next state is FETCH.
- FETCH: iord=0, alu_src_a=0, alu_src_b=1, alu_op=1, pc_write=1, pc_source=0. Next state is FETCH_WAIT.
- FETCH_WAIT: waits MEM_WAIT cycles, then goes to IR_LOAD.
- IR_LOAD: ir_write=1. Next state is DECODE.
- DECODE: write_reg_a=1, write_reg_b=1, aluout_write=1, with alu_src_a=0, alu_src_b=3, alu_op=1 (branch target into ALUOut). Next state by opcode:
  - 0x00 with funct 0x20, 0x22 or 0x24 → EXEC_R
  - 0x08 → EXEC_I
  - 0x23 or 0x2b → ADDR
  - 0x04 or 0x05 → BRANCH
  - 0x02 → JUMP
  - 0x03 → JAL
  - anything else → ILLEGAL
- EXEC_R: alu_src_a=2, alu_src_b=0, aluout_write=1. alu_op is 1 for funct 0x20, 2 for 0x22, 3 for 0x24. Next state is WB_R.
- WB_R: reg_write=1, reg_dst=3, mem_to_reg=0. Next state is FETCH.
- EXEC_I: alu_src_a=2, alu_src_b=2, alu_op=1, aluout_write=1. Next state is WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0. Next state is FETCH.
- ADDR: alu_src_a=2, alu_src_b=2, alu_op=1, aluout_write=1. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord=1. Next state is MEM_WAIT_ST, which waits MEM_WAIT cycles and then goes to WB_LD.
- WB_LD: mdr_write=1, reg_write=1, reg_dst=0, mem_to_reg=1. The register file captures the MDR input path. Next state is FETCH.
- MEM_WR: iord=1, mem_wr=1. Next state is FETCH.
- BRANCH: alu_src_a=2, alu_src_b=0, alu_op=2, pc_source=1. pc_write = zero for beq, !zero for bne. Next state is FETCH.
- JUMP: pc_source=2, pc_write=1. Next state is FETCH.
- JAL: reg_write=1, reg_dst=2, mem_to_reg=2, pc_source=2, pc_write=1. Next state is FETCH.
- ILLEGAL: behaviour per Configuration.

## Timing
- Reset asserted: state is RESET immediately (asynchronous) and the RESET outputs are driven.
- Reset deasserted: FETCH follows at the next rising edge.
- Reset mid-instruction aborts the instruction. No memory write completes unless MEM_WR was already sampled.
- Cycles per instruction, with N = MEM_WAIT:
  - R-type, addi, sw: N+5
  - lw: 2N+6
  - beq, bne, j, jal: N+4
- overflow and zero are sampled in the same cycle as the ALU state that produces them.
- Overflow is ignored on and; it is checked only for add, sub and addi.

## Configuration
- CU_OVERFLOW_TRAP_EN defined:
  - Overflow in EXEC_R (add/sub) or EXEC_I goes to EXCEPT instead of the write-back state. No register write occurs.
  - ILLEGAL also goes to EXCEPT.
  - EXCEPT: alu_src_a=0, alu_src_b=1, alu_op=2 (PC−4), epc_write=1, iord=2. Next state is EXCEPT_WAIT.
  - EXCEPT_WAIT: waits N cycles. Next state is EXCEPT_JMP.
  - EXCEPT_JMP: pc_source=TRAP_VECTOR_SEL, pc_write=1. Next state is FETCH.
- CU_OVERFLOW_TRAP_EN undefined:
  - Overflow is ignored.
  - ILLEGAL returns to FETCH with all outputs 0.
  - epc_write is constant 0 and the EXCEPT states are not built.

## Test plan
- Reset and first fetch (MEM_WAIT=2): pulse reset → RESET outputs are reg_write=1, reg_dst=1, mem_to_reg=5. Next cycle pc_write=1, alu_src_b=1, alu_op=1. ir_write is asserted exactly 3 cycles later.
- add (opcode 0x00, funct 0x20): EXEC_R shows alu_op=1, alu_src_a=2. WB_R follows with reg_write=1, reg_dst=3. Total 7 cycles FETCH→FETCH.
- lw (opcode 0x23): 10 cycles total. The final cycle has mdr_write=1, reg_write=1, mem_to_reg=1. For sw (opcode 0x2b), mem_wr=1 for exactly one cycle with iord=1.
- beq with zero=1 → pc_write=1, pc_source=1. beq with zero=0 → pc_write=0. bne gives the inverse result.
- jal (opcode 0x03): a single cycle with reg_dst=2, mem_to_reg=2, pc_write=1, pc_source=2.
- Trap build: addi with overflow=1 → no reg_write. Then epc_write=1, followed after 2 cycles by pc_source=3, pc_write=1. Illegal opcode 0x3f behaves the same. Non-trap build: 0x3f returns to FETCH.
